// File: rtl/norm_frame_sched.sv
// norm_frame_sched: per-frame crop -> normalize sequencer with frame-max tracking,
// timeout supervision and pixel-count checking. Macro NORM_FRAME_SCHED_AUTORUN_EN adds auto_run.
//   state   | meaning
//   S_IDLE  | waiting for frame_start
//   S_ARM   | waiting for both cores ready, then one joint start pulse
//   S_CROP  | tracking pixel max/count until cf_ap_done
//   S_NORM  | denominator frozen, waiting for nr_ap_done
//   S_DONE  | one-cycle frame completion
//   S_ERROR | timeout; held until err_clear
module norm_frame_sched #(
  parameter int OUT_ROWS       = 10,
  parameter int OUT_COLS       = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        frame_start,
  input  logic        err_clear,
`ifdef NORM_FRAME_SCHED_AUTORUN_EN
  input  logic        auto_run,
`endif
  input  logic        cf_ap_ready,
  output logic        cf_ap_start,
  input  logic        cf_ap_done,
  input  logic        nr_ap_ready,
  output logic        nr_ap_start,
  input  logic        nr_ap_done,
  output logic        seq_ap_idle,
  input  logic        mon_tvalid,
  input  logic        mon_tready,
  input  logic [7:0]  mon_tdata,
  output logic [7:0]  norm_denominator,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        timeout_err,
  output logic        count_err
);

  localparam int PIX_TOTAL = OUT_ROWS * OUT_COLS;
  localparam int PW = $clog2(PIX_TOTAL + 1);
  localparam logic [PW-1:0] PIX_EXP = PW'(PIX_TOTAL);
  localparam logic [PW-1:0] PIX_SAT = '1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TMR_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_CROP  = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [7:0]      max_acc;
  logic [7:0]      max_next;
  logic [PW-1:0]   pix_cnt;
  logic [PW-1:0]   pix_next;
  logic [TW-1:0]   timer;
  logic            beat;
  logic            tmr_tc;
  logic            starts_ok;
  logic            rerun;

  assign beat      = mon_tvalid && mon_tready;
  assign starts_ok = cf_ap_ready && nr_ap_ready;
  // Down-counter loaded on CROP/NORM entry; terminal count ends the allowed window.
  assign tmr_tc    = TMR_EN && (timer == '0);
  assign max_next  = (beat && (mon_tdata > max_acc)) ? mon_tdata : max_acc;
  assign pix_next  = (beat && (pix_cnt != PIX_SAT)) ? pix_cnt + PW'(1) : pix_cnt;

`ifdef NORM_FRAME_SCHED_AUTORUN_EN
  assign rerun = auto_run;
`else
  assign rerun = 1'b0;
`endif

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cf_ap_start = 1'b0;
    nr_ap_start = 1'b0;
    seq_ap_idle = 1'b0;
    busy        = 1'b1;
    frame_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        seq_ap_idle = 1'b1;
        busy        = 1'b0;
        if (frame_start) state_d = S_ARM;
      end
      S_ARM: begin
        seq_ap_idle = 1'b1;
        // Both starts together: the normalizer drops ready on its start, so it
        // must be armed before the crop filter can finish.
        if (starts_ok) begin
          cf_ap_start = 1'b1;
          nr_ap_start = 1'b1;
          state_d     = S_CROP;
        end
      end
      S_CROP: begin
        if (cf_ap_done)  state_d = S_NORM;
        else if (tmr_tc) state_d = S_ERROR;
      end
      S_NORM: begin
        if (nr_ap_done)  state_d = S_DONE;
        else if (tmr_tc) state_d = S_ERROR;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = rerun ? S_ARM : S_IDLE;
      end
      S_ERROR: begin
        if (err_clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      max_acc          <= '0;
      pix_cnt          <= '0;
      timer            <= '0;
      norm_denominator <= 8'd1;
      frame_count      <= '0;
      timeout_err      <= 1'b0;
      count_err        <= 1'b0;
    end else begin
      case (state_q)
        S_ARM: begin
          if (starts_ok) begin
            max_acc <= '0;
            pix_cnt <= '0;
            timer   <= TMR_LOAD;
          end
        end
        S_CROP: begin
          max_acc <= max_next;
          pix_cnt <= pix_next;
          if (cf_ap_done) begin
            norm_denominator <= (max_next == 8'd0) ? 8'd1 : max_next;
            if (pix_next != PIX_EXP) count_err <= 1'b1;
            timer <= TMR_LOAD;
          end else if (tmr_tc) begin
            timeout_err <= 1'b1;
          end else if (timer != '0) begin
            timer <= timer - TW'(1);
          end
        end
        S_NORM: begin
          if (!nr_ap_done) begin
            if (tmr_tc)             timeout_err <= 1'b1;
            else if (timer != '0)   timer <= timer - TW'(1);
          end
        end
        S_DONE: begin
          frame_count <= frame_count + 16'd1;
        end
        S_ERROR: begin
          if (err_clear) begin
            timeout_err <= 1'b0;
            count_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_frame_sched.sv
// Bench for norm_frame_sched: table-driven frames, randomized frames against a frame-level
// model, plus hand sequences for handshake gating, async reset, timeout and autorun.
module tb_norm_frame_sched;

  localparam int ROWS = 10;
  localparam int COLS = 10;
  localparam int NPIX = ROWS * COLS;
  localparam int TO_SHORT = 50;

  logic        clk = 1'b0;
  logic        srst, frame_start, err_clear;
  logic        cf_ap_ready, cf_ap_done, nr_ap_ready, nr_ap_done;
  logic        mon_tvalid, mon_tready;
  logic [7:0]  mon_tdata;
`ifdef NORM_FRAME_SCHED_AUTORUN_EN
  logic        auto_run;
`endif

  logic        cf_ap_start, nr_ap_start, seq_ap_idle, busy, frame_done, timeout_err, count_err;
  logic [7:0]  norm_denominator;
  logic [15:0] frame_count;

  logic        t_cf_ap_start, t_nr_ap_start, t_seq_ap_idle, t_busy, t_frame_done;
  logic        t_timeout_err, t_count_err;
  logic [7:0]  t_norm_denominator;
  logic [15:0] t_frame_count;

  norm_frame_sched #(.OUT_ROWS(ROWS), .OUT_COLS(COLS), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .srst(srst), .frame_start(frame_start), .err_clear(err_clear),
`ifdef NORM_FRAME_SCHED_AUTORUN_EN
    .auto_run(auto_run),
`endif
    .cf_ap_ready(cf_ap_ready), .cf_ap_start(cf_ap_start), .cf_ap_done(cf_ap_done),
    .nr_ap_ready(nr_ap_ready), .nr_ap_start(nr_ap_start), .nr_ap_done(nr_ap_done),
    .seq_ap_idle(seq_ap_idle), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tdata(mon_tdata), .norm_denominator(norm_denominator), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .timeout_err(timeout_err),
    .count_err(count_err)
  );

  // Short-timeout instance sharing the same stimulus; only inspected in the timeout sequence.
  norm_frame_sched #(.OUT_ROWS(ROWS), .OUT_COLS(COLS), .TIMEOUT_CYCLES(TO_SHORT)) dut_to (
    .clk(clk), .srst(srst), .frame_start(frame_start), .err_clear(err_clear),
`ifdef NORM_FRAME_SCHED_AUTORUN_EN
    .auto_run(auto_run),
`endif
    .cf_ap_ready(cf_ap_ready), .cf_ap_start(t_cf_ap_start), .cf_ap_done(cf_ap_done),
    .nr_ap_ready(nr_ap_ready), .nr_ap_start(t_nr_ap_start), .nr_ap_done(nr_ap_done),
    .seq_ap_idle(t_seq_ap_idle), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tdata(mon_tdata), .norm_denominator(t_norm_denominator), .busy(t_busy),
    .frame_done(t_frame_done), .frame_count(t_frame_count), .timeout_err(t_timeout_err),
    .count_err(t_count_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_den_prev = 1;

  typedef logic [7:0] pix_q_t [$];

  typedef struct {
    int nbeats;
    int peak_idx;
    int peak_val;
    int others_max;
    bit done_on_last;
    int nr_delay;
    int exp_den;
    bit exp_cerr;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input pix_q_t pix, input bit done_on_last,
                           input int nr_delay, input int exp_den, input bit exp_cerr,
                           input int exp_fc);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check({tag, "_arm_cf_start"}, cf_ap_start, 1);
    check({tag, "_arm_nr_start"}, nr_ap_start, 1);
    tick();
    check({tag, "_crop_start_low"}, {cf_ap_start, nr_ap_start}, 0);
    check({tag, "_crop_seq_idle"}, seq_ap_idle, 0);
    for (int i = 0; i < pix.size(); i++) begin
      if ($urandom_range(3) == 0) begin
        mon_tvalid = 1'b1; mon_tready = 1'b0; mon_tdata = 8'hFF;
        tick();
        mon_tvalid = 1'b0; mon_tready = 1'b1;
        tick();
      end
      mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tdata = pix[i];
      if (done_on_last && i == pix.size() - 1) cf_ap_done = 1'b1;
      tick();
    end
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tdata = 8'h00;
    if (!done_on_last) begin
      check({tag, "_den_before_done"}, norm_denominator, exp_den_prev);
      cf_ap_done = 1'b1;
      tick();
    end
    cf_ap_done = 1'b0;
    check({tag, "_den"}, norm_denominator, exp_den);
    check({tag, "_count_err"}, count_err, exp_cerr);
    repeat (nr_delay) tick();
    check({tag, "_den_held"}, norm_denominator, exp_den);
    nr_ap_done = 1'b1;
    tick();
    nr_ap_done = 1'b0;
    check({tag, "_frame_done"}, frame_done, 1);
    check({tag, "_fc_in_done"}, frame_count, (exp_fc - 1) & 16'hFFFF);
    tick();
    check({tag, "_fc"}, frame_count, exp_fc & 16'hFFFF);
    check({tag, "_idle"}, {busy, frame_done, seq_ap_idle}, 3'b001);
    check({tag, "_timeout_err"}, timeout_err, 0);
    exp_den_prev = exp_den;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    tick();
    tick();
    srst = 1'b0;
    tick();
    exp_den_prev = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t   vecs[8];
    pix_q_t pix;
    int     exp_fc;
    bit     cerr_model;

    srst = 1'b1; frame_start = 0; err_clear = 0;
    cf_ap_ready = 1; nr_ap_ready = 1; cf_ap_done = 0; nr_ap_done = 0;
    mon_tvalid = 0; mon_tready = 0; mon_tdata = 0;
`ifdef NORM_FRAME_SCHED_AUTORUN_EN
    auto_run = 1'b0;
`endif
    tick();
    check("reset_den", norm_denominator, 1);
    check("reset_flags", {busy, frame_done, timeout_err, count_err, cf_ap_start, nr_ap_start}, 0);
    check("reset_seq_idle", seq_ap_idle, 1);
    check("reset_fc", frame_count, 0);
    srst = 1'b0;
    tick();

    vecs[0] = '{100, 37, 200, 150, 1'b0, 20, 200, 1'b0};
    vecs[1] = '{100, 99, 255, 100, 1'b1, 5, 255, 1'b0};
    vecs[2] = '{100, 0, 0, 0, 1'b0, 3, 1, 1'b0};
    vecs[3] = '{100, 0, 9, 8, 1'b1, 0, 9, 1'b0};
    vecs[4] = '{100, 50, 1, 0, 1'b0, 1, 1, 1'b0};
    vecs[5] = '{99, 10, 150, 120, 1'b0, 2, 150, 1'b1};
    vecs[6] = '{100, 5, 77, 60, 1'b0, 4, 77, 1'b1};
    vecs[7] = '{101, 3, 90, 89, 1'b1, 1, 90, 1'b1};
    exp_fc = 0;
    for (int v = 0; v < 8; v++) begin
      pix.delete();
      for (int i = 0; i < vecs[v].nbeats; i++)
        pix.push_back((i == vecs[v].peak_idx) ? 8'(vecs[v].peak_val)
                                              : 8'((i * 13) % (vecs[v].others_max + 1)));
      exp_fc++;
      run_frame($sformatf("vec%0d", v), pix, vecs[v].done_on_last, vecs[v].nr_delay,
                vecs[v].exp_den, vecs[v].exp_cerr, exp_fc);
    end

    // Handshake gating: no start until both cores report ready.
    cf_ap_ready = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("gate_cf_%0d", c), {cf_ap_start, nr_ap_start, busy, seq_ap_idle}, 4'b0011);
      tick();
    end
    cf_ap_ready = 1'b1; nr_ap_ready = 1'b0;
    #1;
    check("gate_nr", {cf_ap_start, nr_ap_start}, 0);
    tick();
    check("gate_nr_hold", {cf_ap_start, nr_ap_start}, 0);
    nr_ap_ready = 1'b1;
    #1;
    check("gate_release", {cf_ap_start, nr_ap_start}, 2'b11);
    tick();
    check("gate_crop", seq_ap_idle, 0);

    // Async reset in the middle of CROP.
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tdata = 8'd40;
    repeat (3) tick();
    mon_tvalid = 1'b0; mon_tready = 1'b0;
    #2 srst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_den", norm_denominator, 1);
    check("rst_mid_fc", frame_count, 0);
    check("rst_mid_cerr", count_err, 0);
    check("rst_mid_seq_idle", seq_ap_idle, 1);
    tick();
    srst = 1'b0;
    tick();
    exp_den_prev = 1;

    // Randomized frames against a frame-level model.
    exp_fc = 0;
    cerr_model = 1'b0;
    for (int f = 0; f < 6; f++) begin
      int n, lim, mx, den;
      n   = ($urandom_range(4) == 0) ? ($urandom_range(1) ? NPIX + 1 : NPIX - 1) : NPIX;
      lim = $urandom_range(255);
      pix.delete();
      mx = 0;
      for (int i = 0; i < n; i++) begin
        pix.push_back(8'($urandom_range(lim)));
        if (int'(pix[i]) > mx) mx = int'(pix[i]);
      end
      den = (mx == 0) ? 1 : mx;
      if (n != NPIX) cerr_model = 1'b1;
      exp_fc++;
      run_frame($sformatf("rnd%0d", f), pix, 1'($urandom_range(1)), $urandom_range(10),
                den, cerr_model, exp_fc);
    end

    // Timeout: short-timeout instance stalls in NORM.
    do_reset();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tdata = 8'd60;
    repeat (10) tick();
    mon_tvalid = 1'b0; mon_tready = 1'b0;
    cf_ap_done = 1'b1;
    tick();
    cf_ap_done = 1'b0;
    repeat (TO_SHORT - 1) tick();
    check("to_not_yet", {t_timeout_err, t_busy}, 2'b01);
    tick();
    check("to_err", t_timeout_err, 1);
    check("to_busy_seq", {t_busy, t_seq_ap_idle}, 2'b10);
    check("to_count_err", t_count_err, 1);
    check("to_main_ok", {timeout_err, busy, count_err}, 3'b011);
    frame_start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("to_fs_ignored_%0d", c), {t_cf_ap_start, t_nr_ap_start, t_busy}, 3'b001);
      tick();
    end
    frame_start = 1'b0;
    check("to_still_err", t_timeout_err, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("to_cleared", {t_busy, t_timeout_err, t_count_err, t_seq_ap_idle}, 4'b0001);
    check("to_fc", t_frame_count, 0);
    check("main_ignores_clear", {busy, count_err}, 2'b11);
    nr_ap_done = 1'b1;
    tick();
    nr_ap_done = 1'b0;
    check("main_done_after_to", frame_done, 1);
    tick();
    check("main_fc_after_to", frame_count, 1);
    check("main_cerr_persists", {count_err, busy}, 2'b10);
    check("main_den_after_to", norm_denominator, 60);

`ifdef NORM_FRAME_SCHED_AUTORUN_EN
    do_reset();
    auto_run = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int f = 0; f < 3; f++) begin
      check($sformatf("ar_arm_%0d", f), {cf_ap_start, nr_ap_start, busy}, 3'b111);
      tick();
      mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tdata = 8'(f + 10);
      repeat (NPIX) tick();
      mon_tvalid = 1'b0; mon_tready = 1'b0;
      cf_ap_done = 1'b1;
      tick();
      cf_ap_done = 1'b0;
      check($sformatf("ar_den_%0d", f), norm_denominator, f + 10);
      nr_ap_done = 1'b1;
      tick();
      nr_ap_done = 1'b0;
      check($sformatf("ar_done_%0d", f), frame_done, 1);
      if (f == 2) auto_run = 1'b0;
      tick();
      check($sformatf("ar_fc_%0d", f), frame_count, f + 1);
    end
    check("ar_idle_end", {busy, cf_ap_start, count_err}, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
